// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with a run/drain sequencer.
// Produces hsync/vsync, display_on, hpos/vpos and line/frame strobes.
// Scan-out always starts at the frame origin. It stops only after the last
// pixel of a frame, so the monitor never receives a truncated frame.
// Optional build macro VGA_FRAME_CNT_EN adds an 8-bit completed-frame
// counter output frame_cnt.
// Both H_TOTAL and V_TOTAL must not exceed 1024, because the counters are
// 10 bits wide.

module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic       busy
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Sync windows are inclusive at the start and exclusive at the end.
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_n;
  logic   last_pixel;
  logic   h_last;

  assign h_last     = (hpos == H_LAST);
  assign last_pixel = h_last && (vpos == V_LAST);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic: leave IDLE on run, and re-enter IDLE only from the
  // last pixel of a frame that was already draining. A run request always
  // wins over the stop.
  // NOTE: state_n gets a default before the case statement. Every path then
  // assigns it, so no latch can be inferred.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (run) state_n = RUN;
      RUN:     if (!run) state_n = DRAIN;
      DRAIN: begin
        if (run)             state_n = RUN;
        else if (last_pixel) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Raster counters: held at the origin while idle, and free-running while
  // busy. Wrapping from the last pixel also returns the counters to the
  // origin when the frame drains into IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos <= '0;
      vpos <= '0;
    end else if (state == IDLE) begin
      hpos <= '0;
      vpos <= '0;
    end else if (h_last) begin
      hpos <= '0;
      vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos <= hpos + 10'd1;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // Completed-frame counter: counts every frame whose last pixel is
  // scanned, including the final drained frame. It wraps at 256 and holds
  // while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           frame_cnt <= '0;
    else if (state != IDLE && last_pixel) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

  // Output decode. These are purely functions of the registered state and
  // counters, so there is no path from run to any output. The async reset
  // therefore shows on the outputs at once.
  logic hs_active;
  logic vs_active;

  assign busy        = (state != IDLE);
  assign hs_active   = busy && (int'(hpos) >= HS_START) && (int'(hpos) < HS_END);
  assign vs_active   = busy && (int'(vpos) >= VS_START) && (int'(vpos) < VS_END);
  assign hsync       = hs_active ? SYNC_POL : ~SYNC_POL;
  assign vsync       = vs_active ? SYNC_POL : ~SYNC_POL;
  assign display_on  = busy && (int'(hpos) < H_ACTIVE) && (int'(vpos) < V_ACTIVE);
  assign line_start  = busy && (hpos == 10'd0);
  assign frame_start = busy && (hpos == 10'd0) && (vpos == 10'd0);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: self-checking bench for vga_timing_ctrl.
// A reduced raster keeps frames short. The horizontal timing is 8+2+3+3
// (16 clocks) and the vertical timing is 5+1+2+2 (10 lines), giving 160
// clocks per frame.
// A frame-position model is compared with the DUT outputs on every falling
// edge. Directed sections pin the model with literal expectations.

module tb_vga_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 5, VF = 1, VS = 2, VB = 2;
  localparam int HT = 16;
  localparam int VT = 10;
  localparam int FRAME = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       hsync, vsync, display_on, line_start, frame_start, busy;
  logic [9:0] hpos, vpos;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .line_start (line_start),
    .frame_start(frame_start),
    .busy       (busy)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a single position within the frame plus an active
  // flag. Scan-out stops only after the last pixel, and only when run was
  // already low at the previous edge and is still low now.
  bit m_active;
  bit m_run_q;
  int m_pos;
  int m_fcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_run_q  <= 1'b0;
      m_pos    <= 0;
      m_fcnt   <= 0;
    end else begin
      m_run_q <= run;
      if (!m_active) begin
        if (run) begin
          m_active <= 1'b1;
          m_pos    <= 0;
        end
      end else begin
        if (m_pos == FRAME - 1) m_fcnt <= (m_fcnt + 1) % 256;
        if (m_pos == FRAME - 1 && !run && !m_run_q) begin
          m_active <= 1'b0;
          m_pos    <= 0;
        end else begin
          m_pos <= (m_pos + 1) % FRAME;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  bit chk_en = 1'b0;

  always @(negedge clk) begin : cmp
    int h;
    int v;
    if (chk_en && rst_n) begin
      h = m_pos % HT;
      v = m_pos / HT;
      check("m_busy",        busy,        m_active);
      check("m_hpos",        hpos,        h);
      check("m_vpos",        vpos,        v);
      check("m_display_on",  display_on,  m_active && h < HA && v < VA);
      check("m_hsync",       hsync,       (m_active && h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
      check("m_vsync",       vsync,       (m_active && v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
      check("m_line_start",  line_start,  m_active && h == 0);
      check("m_frame_start", frame_start, m_active && m_pos == 0);
`ifdef VGA_FRAME_CNT_EN
      check("m_frame_cnt",   frame_cnt,   m_fcnt);
`endif
    end
  end

  initial begin
    int n;
    bit found;
    int hlow, vlow, lcnt, dcnt, first_h, first_v;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_display_on", display_on, 0);
    check("rst_line_start", line_start, 0);
    check("rst_frame_start", frame_start, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // run sampled on the 10th edge after reset release.
    repeat (9) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_frame_start", frame_start, 1);
    check("start_line_start", line_start, 1);
    check("start_hpos", hpos, 0);
    check("start_vpos", vpos, 0);
    repeat (5) @(negedge clk);
    check("start_hpos5", hpos, 5);

    // One full frame of statistics.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      found = frame_start;
    end
    check("wait_frame_start", found, 1);
    hlow = 0; vlow = 0; lcnt = 0; dcnt = 0; first_h = -1; first_v = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (!hsync) begin
        hlow++;
        if (first_h < 0) first_h = hpos;
      end
      if (!vsync) begin
        vlow++;
        if (first_v < 0) first_v = vpos;
      end
      if (line_start) lcnt++;
      if (display_on) dcnt++;
    end
    @(negedge clk);
    check("frame_start_period", frame_start, 1);
    check("hsync_low_clocks", hlow, 30);
    check("hsync_first_hpos", first_h, 10);
    check("vsync_low_clocks", vlow, 32);
    check("vsync_first_vpos", first_v, 6);
    check("line_starts_per_frame", lcnt, 10);
    check("display_on_clocks", dcnt, 40);

    // Drain from (10,3) with a one-cycle run pulse in the middle.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      found = (hpos == 10 && vpos == 3);
    end
    check("wait_drain_point", found, 1);
    run = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      n++;
      if (n == 20) run = 1'b1;
      if (n == 21) run = 1'b0;
      @(negedge clk);
    end
    check("drain_busy_cycles", n, 102);
    check("drain_busy", busy, 0);
    check("drain_hpos", hpos, 0);
    check("drain_vpos", vpos, 0);
    check("drain_hsync", hsync, 1);
    check("drain_vsync", vsync, 1);

    // Asynchronous reset mid-frame.
    run = 1'b1;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      found = (hpos == 5 && vpos == 2);
    end
    check("wait_reset_point", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_hpos", hpos, 0);
    check("arst_vpos", vpos, 0);
    check("arst_hsync", hsync, 1);
    check("arst_vsync", vsync, 1);
    check("arst_display_on", display_on, 0);
    check("arst_line_start", line_start, 0);
    check("arst_frame_start", frame_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerun_frame_start", frame_start, 1);
    check("rerun_hpos", hpos, 0);
    check("rerun_vpos", vpos, 0);
    check("rerun_busy", busy, 1);

`ifdef VGA_FRAME_CNT_EN
    // Three frames, then drain.
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    n = 0;
    for (int i = 0; i < 5 * FRAME && n < 3; i++) begin
      @(negedge clk);
      if (frame_start) n++;
    end
    check("fcnt_wait3", n, 3);
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      found = !busy;
    end
    check("fcnt_wait_idle3", found, 1);
    check("fcnt_three", frame_cnt, 3);
    repeat (20) @(negedge clk);
    check("fcnt_hold", frame_cnt, 3);

    // 256 frames wrap the counter to zero.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    n = 0;
    for (int i = 0; i < 260 * FRAME && n < 256; i++) begin
      @(negedge clk);
      if (frame_start) n++;
    end
    check("fcnt_wait256", n, 256);
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      found = !busy;
    end
    check("fcnt_wait_idle256", found, 1);
    check("fcnt_wrap", frame_cnt, 0);
`endif

    // Randomised run patterns: long holds, per-cycle toggling and rare drops.
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      int style;
      bit hold;
      len   = $urandom_range(1, 300);
      style = $urandom_range(0, 2);
      hold  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        case (style)
          0:       run = hold;
          1:       run = 1'($urandom_range(0, 1));
          default: run = ($urandom_range(0, 15) != 0);
        endcase
      end
    end
    run = 1'b0;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge clk);
      found = !busy;
    end
    check("final_idle", found, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences the VGA pixel datapath inside the tt_um top level.
- Generates hsync, vsync, display_on and pixel coordinates hpos/vpos, plus line/frame strobes for the colour logic feeding uo_out.
- A run/drain FSM starts scan-out cleanly at frame origin and stops only on a frame boundary, so the monitor never sees a truncated frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low, as 640x480@60)

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- run  in  1  request scan-out; level-sensitive
- hsync  out  1  horizontal sync at SYNC_POL when asserted
- vsync  out  1  vertical sync at SYNC_POL when asserted
- display_on  out  1  high while hpos < H_ACTIVE and vpos < V_ACTIVE, and not IDLE
- hpos  out  10  horizontal counter 0..H_TOTAL-1
- vpos  out  10  vertical counter 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse at hpos==0 while not IDLE
- frame_start  out  1  one-cycle pulse at hpos==0 && vpos==0 while not IDLE
- busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Both totals must be ≤ 1024. Counters are 10 bits, unsigned, with no saturation.
- Reset (async, rst_n low) applies immediately:
  - state=IDLE, hpos=0, vpos=0
  - hsync=vsync=~SYNC_POL
  - display_on, line_start, frame_start, busy all 0
- All outputs are registered or decoded from registered state only; no combinational path from run to any output.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0; syncs deasserted; strobes 0. If run=1 at clock edge N, then state=RUN at edge N+1 with hpos=0, vpos=0, frame_start=1 and line_start=1 in that cycle.
  - RUN: hpos increments every clock. At hpos==H_TOTAL-1, hpos→0 and vpos increments. At hpos==H_TOTAL-1 && vpos==V_TOTAL-1, both wrap to 0. If run=0, next state=DRAIN and counting continues uninterrupted.
  - DRAIN: counts identically to RUN.
    - If run=1, return to RUN with no counter disturbance.
    - At the last pixel (H_TOTAL-1, V_TOTAL-1) with run=0, next state=IDLE and counters go to 0.
    - If run=1 on that same last pixel, go to RUN and wrap normally; the RUN transition takes priority.
- Sync decode, valid whenever not IDLE and aligned to the same cycle as hpos/vpos:
  - hsync=SYNC_POL iff H_ACTIVE+H_FP ≤ hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync=SYNC_POL iff V_ACTIVE+V_FP ≤ vpos < V_ACTIVE+V_FP+V_SYNC. vsync changes only on cycles where hpos==0.
- Pixel latency: colour logic sampling hpos/vpos/display_on in cycle N drives its registered output in N+1. Top level delays hsync/vsync by one register to match; that register is not part of this block.
- run toggling faster than one frame never produces a partial frame. IDLE is entered only from the last pixel.
- Reset asserted mid-frame aborts immediately to the reset values; no drain.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds output port frame_cnt (8 bits, reset 0).
  - Increments on each transition off the last pixel (H_TOTAL-1, V_TOTAL-1) in RUN or DRAIN, including the final drain frame; wraps 255→0.
  - Holds in IDLE; cleared only by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then run=1 at cycle 10 → busy=1, frame_start=1, hpos=0, vpos=0 at cycle 11; hpos=5 at cycle 16.
- Free run, defaults → hsync low for exactly 96 clocks per line, starting at hpos=656; line_start period 800 clocks; vsync low for exactly 2 lines at vpos 490-491; frame_start period 420000 clocks.
- display_on → high for 640 clocks per line on vpos 0..479, and 0 for vpos ≥ 480 or hpos ≥ 640.
- run=0 at hpos=100, vpos=200 → busy stays 1 until cycle after (799,524), then IDLE with hpos=vpos=0 and hsync=vsync=1. run pulse 0→1 during DRAIN → no counter discontinuity.
- rst_n low at hpos=300, vpos=100 → outputs reach reset values immediately, without waiting for a clock edge; release with run=1 → new frame starts at (0,0).
- VGA_FRAME_CNT_EN: run 3 frames then drain → frame_cnt=3 held in IDLE. Preload via 256 frames → wraps to 0.
